reg_pipe_hs: RTL

//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data with valid/ready handshake.

---
 rtl/reg_pipe_hs.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_pipe_hs.sv
// Elastic valid/ready register pipeline: DEPTH stages, bubble collapse, flush, optional registered-ready skid entry.
// Latency DEPTH edges; out_ready low stalls from the output end, in_ready drops once DEPTH+REG_READY beats are held.
module reg_pipe_hs #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 2,
  parameter int unsigned      REG_READY = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);

  localparam int unsigned OW   = $clog2(DEPTH+2);
  localparam bit          SKID = (REG_READY != 0);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [DEPTH:0]   rdy;
  logic             in_acc;
  logic             src_vld;
  logic [WIDTH-1:0] src_dat;

  // rdy[k]: stage k may load this cycle (empty, or its occupant moves on).
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready && !flush;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  // The rst term keeps the registered ready low while the block is held in reset.
  assign in_ready = SKID ? (!skid_v_q && !rst && !flush) : (rdy[0] && !flush);
  assign in_acc   = in_valid && in_ready;
  assign src_vld  = skid_v_q || in_acc;
  assign src_dat  = skid_v_q ? skid_dat_q : in_data;

  always_comb begin
    v_d        = v_q;
    dat_d      = dat_q;
    skid_v_d   = skid_v_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      v_d      = '0;
      skid_v_d = 1'b0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = src_vld;
        if (src_vld) dat_d[0] = src_dat;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) dat_d[k] = dat_q[k-1];
        end
      end
      // Skid holds the beat accepted while stage 0 was blocked; it drains ahead of new input.
      if (skid_v_q && rdy[0]) begin
        skid_v_d = 1'b0;
      end else if (in_acc && !rdy[0]) begin
        skid_v_d   = 1'b1;
        skid_dat_d = in_data;
      end
    end
  end

  always_comb begin
    occ_d = OW'(skid_v_d);
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_d = occ_d + OW'(v_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= '0;
      skid_v_q   <= 1'b0;
      skid_dat_q <= RESET_VAL;
      occ_q      <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dat_q[k] <= RESET_VAL;
      end
    end else begin
      v_q        <= v_d;
      skid_v_q   <= skid_v_d;
      skid_dat_q <= skid_dat_d;
      occ_q      <= occ_d;
      dat_q      <= dat_d;
    end
  end

  assign out_valid = v_q[DEPTH-1] && !flush;
  assign out_data  = dat_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
